// File: rtl/regfile_sb_if.sv
// Port bundle between decode/writeback and the regfile_sb register file.
// The master side (decode, writeback, issue) drives requests; the slave side is the register file.
interface regfile_sb_if #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_wd;
    logic              issue_wreg;
    logic              issue_is_load;
    logic              flush;
    logic              stall_req;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
               issue_valid, issue_wd, issue_wreg, issue_is_load, flush,
        input  rdata1, rdata2, stall_req, busy_mask
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
               issue_valid, issue_wd, issue_wreg, issue_is_load, flush,
        output rdata1, rdata2, stall_req, busy_mask
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports and a load-use scoreboard.
// Define RF_WRITE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb #(
    parameter int LOAD_SHADOW = 1,
    parameter int NUM_REGS    = 32,
    parameter int DATA_W      = 32
) (
    input logic clk,
    input logic rst,
    regfile_sb_if.slave rf
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [2:0] SHADOW = 3'(LOAD_SHADOW);

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic              issue_hit;

    function automatic logic [DATA_W-1:0] read_port(
        input logic              in_rst,
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        if (in_rst || !en || addr == '0)
            return '0;
        if (BYPASS && wr_en && wr_addr == addr)
            return wr_data;
        return stored;
    endfunction

    // Architectural state: r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (rf.we && rf.waddr != '0) begin
            regs[rf.waddr] <= rf.wdata;
        end
    end

    assign issue_hit = rf.issue_valid && rf.issue_wreg && rf.issue_wd != '0;

    // Per-register load shadow counters; an issue to a register overrides its own decrement.
    always_ff @(posedge clk) begin
        if (rst || rf.flush) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue_hit && rf.issue_wd == ADDR_W'(i))
                    cnt[i] <= rf.issue_is_load ? SHADOW : 3'd0;
                else if (cnt[i] != 3'd0)
                    cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end

    assign busy[0] = 1'b0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_busy
        assign busy[g] = (cnt[g] != 3'd0);
    end

    assign rf.rdata1 = read_port(rst, rf.re1, rf.raddr1, rf.we, rf.waddr, rf.wdata,
                                 regs[rf.raddr1]);
    assign rf.rdata2 = read_port(rst, rf.re2, rf.raddr2, rf.we, rf.waddr, rf.wdata,
                                 regs[rf.raddr2]);

    // Stall looks only at current counters; an issue in this cycle is seen next cycle.
    assign rf.stall_req = !rst && ((rf.re1 && rf.raddr1 != '0 && busy[rf.raddr1]) ||
                                   (rf.re2 && rf.raddr2 != '0 && busy[rf.raddr2]));
    assign rf.busy_mask = rst ? '0 : busy;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file that answers the decode stage's two read-port requests (reg1/reg2 read enable + address) and accepts one writeback per cycle.
- Integrated load-use scoreboard. It tracks destinations of in-flight loads whose data is not yet forwardable, and raises stall_req so decode holds until the EX/MEM forward paths can supply the operand.
- Sits beside the decode stage; writeback drives the write port; decode-to-EX issue drives the scoreboard.

Parameters:
- LOAD_SHADOW, 1, cycles after issue during which a load's destination is not forwardable (load in EX); range 1..7.
- NUM_REGS, 32, architectural registers; address width log2(NUM_REGS)=5.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  writeback enable
- waddr  in  5  writeback register address
- wdata  in  32  writeback data
- re1  in  1  read port 1 enable
- raddr1  in  5  read port 1 address
- rdata1  out  32  read port 1 data (combinational)
- re2  in  1  read port 2 enable
- raddr2  in  5  read port 2 address
- rdata2  out  32  read port 2 data (combinational)
- issue_valid  in  1  an instruction moves decode->EX this cycle
- issue_wd  in  5  its destination register
- issue_wreg  in  1  it writes a register
- issue_is_load  in  1  it is a load
- flush  in  1  discard all in-flight scoreboard entries
- stall_req  out  1  decode must hold (combinational)
- busy_mask  out  32  per-register pending-load flags, registered view

Behaviour:
- Reset (rst=1 at clk edge): all registers cleared to 0, all scoreboard counters cleared. While rst is high: rdata1/rdata2=0, stall_req=0, busy_mask=0.
- Register 0 is hardwired to 0. Writes with waddr=0 are ignored. Reads of address 0 return 0.
- Write: on a clk edge with we=1 and waddr!=0, reg[waddr]<=wdata.
- Read priority (per port, rst=0):
  - re=0 -> 0.
  - addr=0 -> 0.
  - bypass: we=1 and waddr==addr -> wdata (see Optional Feature).
  - otherwise reg[addr].
- Scoreboard: one counter per register, width 3 bits; busy[r] = (cnt[r]!=0).
- Counter update each clk edge, highest priority first:
  - flush=1 -> all counters 0.
  - issue_valid & issue_wreg & issue_wd!=0 & issue_is_load -> cnt[issue_wd]<=LOAD_SHADOW. This reloads an already-busy register and wins over that register's same-cycle decrement.
  - issue_valid & issue_wreg & issue_wd!=0 & !issue_is_load -> cnt[issue_wd]<=0. A younger non-load writer supersedes the pending load; its result is forwardable from EX.
  - All other counters: nonzero -> decrement.
- stall_req = (re1 & raddr1!=0 & busy[raddr1]) | (re2 & raddr2!=0 & busy[raddr2]). It uses current counter state only; the same-cycle issue takes effect next cycle.
- While stall_req=1, the pipeline drives issue_valid=0 (bubble). Counters still decrement, so with LOAD_SHADOW=1 a dependent instruction stalls exactly 1 cycle.
- busy_mask[r] = busy[r]; bit 0 is always 0.
- rst asserted mid-operation overrides flush and issue; all state is cleared on that edge.
- Writeback never clears scoreboard entries; only counter expiry, flush, or a superseding issue do.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- Defined: the read-priority bypass rule is active; a same-cycle writeback to the read address returns wdata.
- Undefined: the bypass rule is removed; reads return reg[addr] (pre-write value) during the write cycle, and the new value is visible from the next cycle. The decode stage then relies on its own forwarding.

Test Plan:
- Reset, then read r1..r31 with re1=re2=1 -> all reads 0, stall_req=0, busy_mask=0.
- Write r5=0x1234ABCD (we=1); next cycle read raddr1=5 -> 0x1234ABCD. Write r0=0xFFFFFFFF -> raddr2=0 reads 0.
- Bypass case: same cycle we=1, waddr=7, wdata=0xDEADBEEF, raddr1=7, with r7 previously 0x11.
  - RF_WRITE_BYPASS_EN defined -> rdata1=0xDEADBEEF.
  - Undefined -> rdata1=0x11.
  - Either way, next cycle rdata1=0xDEADBEEF.
- Load-use, LOAD_SHADOW=1: issue load to r8; next cycle re2=1, raddr2=8 -> stall_req=1 for exactly 1 cycle, then 0. With LOAD_SHADOW=3 -> stall_req high for 3 cycles.
- Supersede and reload:
  - Load to r9 issued, then next cycle a non-load issued with wd=9 -> busy_mask[9]=0 the following cycle.
  - Load to r9 issued while cnt[9]=1 -> busy_mask[9] stays 1, counter reloaded to LOAD_SHADOW.
- Flush/reset mid-stall: busy r10, flush=1 -> next cycle busy_mask=0 and stall_req=0 for raddr1=10. Repeat with rst=1 instead of flush -> registers also read 0.
